// File: rtl/ptp_punch.sv
// ptp_punch: paper-tape punch responder on the processor IO bus.
// Decodes its device code, accepts CONO/DATAO strobes, hands frames to the
// punch mechanism over valid/ready, times the mechanism cycle, and reports
// status on CONI plus a PI request on the programmed channel.
// Optional feature: define PTP_FEED_EN to add the tape-feed (blank frame) mode.
module ptp_punch #(
  parameter logic [6:0]  DEVCODE      = 7'o20,
  parameter int unsigned PUNCH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_poweron,
  input  logic        iobus_iob_reset,
  input  logic        iobus_datao_clear,
  input  logic        iobus_datao_set,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_iob_fm_datai,
  input  logic        iobus_iob_fm_status,
  input  logic [3:9]  iobus_ios,
  input  logic [0:35] iobus_iob_in,
  output logic [0:35] iobus_iob_out,
  output logic [1:7]  iobus_pi_req,
  output logic [7:0]  punch_data,
  output logic        punch_valid,
  input  logic        punch_ready,
  input  logic        sw_feed
);

  localparam logic [15:0] CNT_LOAD = 16'(PUNCH_CYCLES - 1);

`ifdef PTP_FEED_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_FEED, S_FEED_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
`endif

  state_t      state, state_next;
  logic [0:7]  frame_buf;
  logic [0:2]  pia;
  logic        done, busy, bin;
  logic [15:0] cnt;

  logic        sel, clr;
  logic        cono_clr, cono_set_sel, datao_clr, datao_take;
  logic        cnt_load, counting, job_done;
  logic        feed_start, feed_stop;
  logic [0:35] status_word, datai_word;

  // Bus decode: strobes only count when our device code is selected.
  always_comb begin
    sel          = (iobus_ios == DEVCODE);
    clr          = ~reset | ~iobus_iob_poweron | iobus_iob_reset;
    cono_clr     = sel & iobus_cono_clear;
    cono_set_sel = sel & iobus_cono_set;
    datao_clr    = sel & iobus_datao_clear;
    datao_take   = sel & iobus_datao_set & (state == S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next state and punch handshake outputs.
  always_comb begin
    state_next  = state;
    punch_valid = 1'b0;
    punch_data  = '0;
    cnt_load    = 1'b0;
    counting    = 1'b0;
    job_done    = 1'b0;
    feed_start  = 1'b0;
    feed_stop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (datao_take) state_next = S_SEND;
`ifdef PTP_FEED_EN
        else if (sw_feed) begin
          state_next = S_FEED;
          feed_start = 1'b1;
        end
`endif
      end
      S_SEND: begin
        punch_valid = 1'b1;
        punch_data  = bin ? {2'b10, frame_buf[2:7]} : frame_buf;
        if (punch_ready) begin
          cnt_load   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        counting = 1'b1;
        if (cnt == '0) begin
          job_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
`ifdef PTP_FEED_EN
      S_FEED: begin
        punch_valid = 1'b1;
        punch_data  = 8'h00;
        if (punch_ready) begin
          cnt_load   = 1'b1;
          state_next = S_FEED_WAIT;
        end
      end
      S_FEED_WAIT: begin
        counting = 1'b1;
        if (cnt == '0) begin
          if (sw_feed) state_next = S_FEED;
          else begin
            feed_stop  = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Device registers; clear strobes act before set strobes in the same clock.
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_buf <= '0;
      pia       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bin       <= 1'b0;
      cnt       <= '0;
    end else begin
      pia       <= (cono_clr ? 3'b000 : pia) | (cono_set_sel ? iobus_iob_in[33:35] : 3'b000);
      bin       <= (bin & ~cono_clr) | (cono_set_sel & iobus_iob_in[30]);
      done      <= job_done |
                   (~datao_take & ((done & ~cono_clr) | (cono_set_sel & iobus_iob_in[32])));
      frame_buf <= (datao_clr ? 8'h00 : frame_buf) | (datao_take ? iobus_iob_in[28:35] : 8'h00);
      if (datao_take | feed_start)     busy <= 1'b1;
      else if (job_done | feed_stop)   busy <= 1'b0;
      if (cnt_load)                    cnt <= CNT_LOAD;
      else if (counting && cnt != '0)  cnt <= cnt - 16'd1;
    end
  end

  // Read-back words; the bus is wire-ORed so drive zero unless selected.
  always_comb begin
    status_word         = '0;
    status_word[30]     = bin;
    status_word[31]     = busy;
    status_word[32]     = done;
    status_word[33:35]  = pia;
    datai_word          = '0;
    datai_word[28:35]   = frame_buf;
    iobus_iob_out       = ((sel & iobus_iob_fm_status) ? status_word : 36'd0) |
                          ((sel & iobus_iob_fm_datai)  ? datai_word  : 36'd0);
  end

  // Priority-interrupt request on the channel held in pia.
  always_comb begin
    iobus_pi_req = '0;
    for (int unsigned n = 1; n <= 7; n++)
      iobus_pi_req[n] = done & (pia == 3'(n));
  end

  logic unused_inputs;
`ifdef PTP_FEED_EN
  assign unused_inputs = ^iobus_iob_in[0:27];
`else
  assign unused_inputs = ^{iobus_iob_in[0:27], sw_feed};
`endif

endmodule

// File: tb/tb_ptp_punch.sv
// Self-checking bench for ptp_punch: scenario tasks plus a frame scoreboard.
module tb_ptp_punch;

  localparam logic [6:0] DEV = 7'o20;

  logic        clk = 1'b0;
  logic        reset, poweron, iob_reset;
  logic        datao_clear, datao_set, cono_clear, cono_set;
  logic        fm_datai, fm_status;
  logic [3:9]  ios;
  logic [0:35] iob_in, iob_out;
  logic [1:7]  pi_req;
  logic [7:0]  punch_data;
  logic        punch_valid, punch_ready, sw_feed;

  int          checks = 0;
  int          passed = 0;
  logic [7:0]  exp_q[$];
  logic        feed_mode = 1'b0;

  ptp_punch #(.DEVCODE(DEV), .PUNCH_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .iobus_iob_poweron(poweron),
    .iobus_iob_reset(iob_reset), .iobus_datao_clear(datao_clear),
    .iobus_datao_set(datao_set), .iobus_cono_clear(cono_clear),
    .iobus_cono_set(cono_set), .iobus_iob_fm_datai(fm_datai),
    .iobus_iob_fm_status(fm_status), .iobus_ios(ios),
    .iobus_iob_in(iob_in), .iobus_iob_out(iob_out), .iobus_pi_req(pi_req),
    .punch_data(punch_data), .punch_valid(punch_valid),
    .punch_ready(punch_ready), .sw_feed(sw_feed)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted frame must match the next expected one.
  always @(negedge clk) begin
    if (!feed_mode && punch_valid && punch_ready) begin
      checks++;
      if (exp_q.size() == 0)
        $display("FAIL frame_unexpected: got %h, none expected", punch_data);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (punch_data !== e) $display("FAIL frame_data: got %h, expected %h", punch_data, e);
        else passed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cono(input logic c, input logic s, input logic [0:35] d);
    iob_in = d; cono_clear = c; cono_set = s;
    step();
    cono_clear = 0; cono_set = 0; iob_in = '0;
  endtask

  task automatic do_datao(input logic c, input logic s, input logic [0:35] d);
    iob_in = d; datao_clear = c; datao_set = s;
    step();
    datao_clear = 0; datao_set = 0; iob_in = '0;
  endtask

  task automatic read_status(output logic [0:35] w);
    fm_status = 1; #1; w = iob_out; fm_status = 0; #1;
  endtask

  task automatic test_reset();
    logic [0:35] w;
    reset = 0; step(); step(); reset = 1;
    fm_status = 1; fm_datai = 1; #1; w = iob_out; fm_status = 0; fm_datai = 0;
    checks++; if (w !== 36'd0) $display("FAIL reset_iob_out: got %o, expected 0", w); else passed++;
    checks++; if (pi_req !== 7'd0) $display("FAIL reset_pi_req: got %b, expected 0", pi_req); else passed++;
    checks++; if (punch_valid !== 1'b0 || punch_data !== 8'h00)
      $display("FAIL reset_punch: got valid=%b data=%h, expected 0/00", punch_valid, punch_data);
    else passed++;
  endtask

  task automatic test_status();
    logic [0:35] w;
    do_cono(0, 1, 36'o5);
    read_status(w);
    checks++; if (w !== 36'o5) $display("FAIL status_roundtrip: got %o, expected 5", w); else passed++;
    do_cono(1, 0, '0);
    ios = 7'o21;
    do_cono(0, 1, 36'o7);
    read_status(w);
    checks++; if (w !== 36'd0) $display("FAIL status_unselected_read: got %o, expected 0", w); else passed++;
    ios = DEV;
    read_status(w);
    checks++; if (w !== 36'd0) $display("FAIL status_unselected_set: got %o, expected 0", w); else passed++;
  endtask

  task automatic test_ascii();
    logic [0:35] w;
    do_cono(0, 1, 36'o5);
    punch_ready = 1;
    exp_q.push_back(8'h41);
    do_datao(0, 1, 36'o101);
    checks++; if (punch_valid !== 1'b1 || punch_data !== 8'h41)
      $display("FAIL ascii_offer: got valid=%b data=%h, expected 1/41", punch_valid, punch_data);
    else passed++;
    step();
    repeat (15) step();
    read_status(w);
    checks++; if (w !== 36'o25) $display("FAIL ascii_busy_before_done: got %o, expected 25", w); else passed++;
    checks++; if (pi_req !== 7'd0) $display("FAIL ascii_pi_early: got %b, expected 0", pi_req); else passed++;
    step();
    read_status(w);
    checks++; if (w !== 36'o15) $display("FAIL ascii_done_timing: got %o, expected 15", w); else passed++;
    checks++; if (pi_req !== 7'b0000100) $display("FAIL ascii_pi_req: got %b, expected 0000100", pi_req); else passed++;
    fm_datai = 1; #1; w = iob_out; fm_datai = 0;
    checks++; if (w !== 36'h41) $display("FAIL ascii_datai: got %h, expected 41", w); else passed++;
    do_cono(1, 0, '0);
    checks++; if (pi_req !== 7'd0) $display("FAIL pi_drop_on_cono_clear: got %b, expected 0", pi_req); else passed++;
  endtask

  task automatic test_backpressure();
    logic [0:35] w;
    logic bad;
    do_cono(0, 1, 36'o40);
    punch_ready = 0;
    exp_q.push_back(8'hBF);
    do_datao(1, 1, 36'h3F);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (punch_valid !== 1'b1 || punch_data !== 8'hBF) bad = 1;
      step();
    end
    checks++; if (bad !== 1'b0 || punch_valid !== 1'b1 || punch_data !== 8'hBF)
      $display("FAIL bp_hold: got valid=%b data=%h, expected 1/bf held", punch_valid, punch_data);
    else passed++;
    read_status(w);
    checks++; if (w !== 36'o60) $display("FAIL bp_status_waiting: got %o, expected 60", w); else passed++;
    punch_ready = 1;
    step();
    repeat (15) step();
    read_status(w);
    checks++; if (w !== 36'o60) $display("FAIL bp_before_done: got %o, expected 60", w); else passed++;
    step();
    read_status(w);
    checks++; if (w !== 36'o50) $display("FAIL bp_done_timing: got %o, expected 50", w); else passed++;
  endtask

  task automatic test_busy_collision();
    logic [0:35] w;
    do_cono(1, 0, '0);
    punch_ready = 1;
    exp_q.push_back(8'h12);
    do_datao(1, 1, 36'h12);
    step();
    do_datao(0, 1, 36'h55);
    fm_datai = 1; #1; w = iob_out; fm_datai = 0;
    checks++; if (w !== 36'h12) $display("FAIL collision_buf: got %h, expected 12", w); else passed++;
    checks++; if (punch_valid !== 1'b0) $display("FAIL collision_valid: got %b, expected 0", punch_valid); else passed++;
    repeat (14) step();
    read_status(w);
    checks++; if (w !== 36'o20) $display("FAIL collision_before_done: got %o, expected 20", w); else passed++;
    step();
    read_status(w);
    checks++; if (w !== 36'o10) $display("FAIL collision_done_timing: got %o, expected 10", w); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [0:35] w;
    for (int m = 0; m < 3; m++) begin
      punch_ready = 0;
      do_datao(1, 1, 36'hA5);
      do_cono(0, 1, 36'o13);
      checks++; if (punch_valid !== 1'b1 || pi_req !== 7'b0010000)
        $display("FAIL rst%0d_setup: got valid=%b pi=%b, expected 1/0010000", m, punch_valid, pi_req);
      else passed++;
      case (m)
        0: iob_reset = 1;
        1: reset = 0;
        default: poweron = 0;
      endcase
      step();
      iob_reset = 0; reset = 1; poweron = 1;
      checks++; if (punch_valid !== 1'b0) $display("FAIL rst%0d_valid: got %b, expected 0", m, punch_valid); else passed++;
      fm_status = 1; fm_datai = 1; #1; w = iob_out; fm_status = 0; fm_datai = 0;
      checks++; if (w !== 36'd0) $display("FAIL rst%0d_iob_out: got %o, expected 0", m, w); else passed++;
      checks++; if (pi_req !== 7'd0) $display("FAIL rst%0d_pi_req: got %b, expected 0", m, pi_req); else passed++;
    end
  endtask

`ifdef PTP_FEED_EN
  task automatic test_feed();
    logic [0:35] w;
    int acc[$];
    feed_mode = 1;
    punch_ready = 1;
    sw_feed = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) sw_feed = 0;
      if (punch_valid && punch_ready) begin
        acc.push_back(i);
        if (punch_data !== 8'h00) $display("FAIL feed_data: got %h, expected 00", punch_data);
      end
      if (i == 5) begin
        read_status(w);
        checks++; if (w !== 36'o20) $display("FAIL feed_busy: got %o, expected 20", w); else passed++;
      end
      step();
    end
    checks++; if (acc.size() != 3) $display("FAIL feed_count: got %0d, expected 3", acc.size());
    else if (acc[1] - acc[0] != 17 || acc[2] - acc[1] != 17)
      $display("FAIL feed_spacing: got %0d,%0d expected 17,17", acc[1] - acc[0], acc[2] - acc[1]);
    else passed++;
    read_status(w);
    checks++; if (w !== 36'd0) $display("FAIL feed_idle_status: got %o, expected 0", w); else passed++;
    feed_mode = 0;
  endtask
`endif

  initial begin
    reset = 0; poweron = 1; iob_reset = 0;
    datao_clear = 0; datao_set = 0; cono_clear = 0; cono_set = 0;
    fm_datai = 0; fm_status = 0; ios = DEV; iob_in = '0;
    punch_ready = 0; sw_feed = 0;
    test_reset();
    test_status();
    test_ascii();
    test_backpressure();
    test_busy_collision();
    test_reset_mid();
`ifdef PTP_FEED_EN
    test_feed();
`endif
    step();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
